// File: rtl/scratchpad_arb_pkg.sv
// Shared types and constants for the scratchpad port arbiter.
// The struct widths follow the DEF_* values; keep them in step with the top-level parameters.
package scratchpad_arb_pkg;
  localparam int DEF_NUM_REQ    = 3;
  localparam int DEF_ADDR_WIDTH = 29;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_MASK_WIDTH = DEF_DATA_WIDTH / 8;
  localparam int DEF_MAX_WAIT   = 4;
  localparam int REQ_ID_W       = $clog2(DEF_NUM_REQ);
  localparam int PRIORITY_REQ   = 0;

  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
    logic [DEF_MASK_WIDTH-1:0] mask;
  } scratchpad_req_t;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } scratchpad_rsp_t;
endpackage

// File: rtl/scratchpad_port_arbiter_rr_picker.sv
// Combinational rotating-priority picker: one-hot grant to the first request after i_ptr, with wrap.
module rr_picker
  import scratchpad_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);
  // Walk from the farthest candidate back to the nearest so the nearest valid one wins.
  always_comb begin
    o_gnt = '0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_gnt = '0;
        o_gnt[(int'(i_ptr) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/scratchpad_port_arbiter.sv
// Shares the single scratchpad port: requester 0 has starvation-bounded priority,
// the rest are served round-robin; responses return one cycle after the grant.
module scratchpad_port_arbiter
  import scratchpad_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*MASK_WIDTH-1:0] req_mask,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         scratchpad_write_o,
  output logic [ADDR_WIDTH-1:0]        scratchpad_addr_o,
  output logic [DATA_WIDTH-1:0]        scratchpad_wdata_o,
  output logic [MASK_WIDTH-1:0]        scratchpad_mask_o,
  input  logic [DATA_WIDTH-1:0]        scratchpad_rdata_i
);
  localparam int NP    = NUM_REQ - 1;
  localparam int PTR_W = (NP > 1) ? $clog2(NP) : 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]    r_starve_cnt;
  logic [REQ_ID_W-1:0] r_rr_ptr;
  scratchpad_rsp_t     r_pend;
  logic                r_pend_write;

  logic [NP-1:0]       w_np_valid;
  logic [NP-1:0]       w_np_gnt;
  logic [PTR_W-1:0]    w_np_ptr;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_gnt_any;
  logic [REQ_ID_W-1:0] w_gnt_id;
  scratchpad_req_t     w_win;

  // The picker only sees requesters 1..NUM_REQ-1, so its pointer is rr_ptr shifted down by one.
  assign w_np_valid = req_valid[NUM_REQ-1:1];
  assign w_np_ptr   = PTR_W'(r_rr_ptr - 1'b1);

  rr_picker #(
    .N     (NP),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .i_req (w_np_valid),
    .i_ptr (w_np_ptr),
    .o_gnt (w_np_gnt)
  );

  always_comb begin
    w_gnt = '0;
    if (!rst) begin
      if (req_valid[PRIORITY_REQ] && (r_starve_cnt < CNT_W'(MAX_WAIT)))
        w_gnt[PRIORITY_REQ] = 1'b1;
      else if (|w_np_valid)
        w_gnt[NUM_REQ-1:1] = w_np_gnt;
      else if (req_valid[PRIORITY_REQ])
        w_gnt[PRIORITY_REQ] = 1'b1;
    end
  end

  assign req_ready = w_gnt;
  assign w_gnt_any = |w_gnt;

  always_comb begin
    w_win    = '0;
    w_gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_id    = REQ_ID_W'(i);
        w_win.write = req_write[i];
        w_win.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_win.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_win.mask  = req_mask[i*MASK_WIDTH +: MASK_WIDTH];
      end
    end
  end

  assign scratchpad_write_o = w_win.write;
  assign scratchpad_addr_o  = w_win.addr;
  assign scratchpad_wdata_o = w_win.wdata;
  assign scratchpad_mask_o  = w_win.mask;

  // Grant stage -> response stage boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_rr_ptr     <= REQ_ID_W'(NUM_REQ - 1);
      r_pend       <= '0;
      r_pend_write <= 1'b0;
    end else begin
      r_pend.valid <= w_gnt_any;
      r_pend.id    <= w_gnt_id;
      r_pend_write <= w_win.write;
      if (w_gnt_any && !w_gnt[PRIORITY_REQ]) begin
        r_rr_ptr     <= w_gnt_id;
        r_starve_cnt <= '0;
      end else if (!(|w_np_valid)) begin
        r_starve_cnt <= '0;
      end else if (w_gnt[PRIORITY_REQ] && (r_starve_cnt != CNT_W'(MAX_WAIT))) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  // Reset in the response cycle drops the in-flight response.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (!rst && r_pend.valid) begin
      rsp_valid[r_pend.id] = 1'b1;
      if (!r_pend_write)
        rsp_rdata = scratchpad_rdata_i;
    end
  end

  a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));
  a_rsp_onehot0   : assert property (@(posedge clk) $onehot0(rsp_valid));
  a_no_gnt_in_rst : assert property (@(posedge clk) rst |-> (req_ready == '0));
endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// Directed and randomized checks of the scratchpad arbiter against a rule-level reference model.
module tb_scratchpad_port_arbiter;
  localparam int N    = 3;
  localparam int AW   = 29;
  localparam int DW   = 64;
  localparam int MW   = 8;
  localparam int MAXW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*MW-1:0] req_mask;
  logic [DW-1:0]   rsp_rdata, scratchpad_wdata_o, scratchpad_rdata_i;
  logic            scratchpad_write_o;
  logic [AW-1:0]   scratchpad_addr_o;
  logic [MW-1:0]   scratchpad_mask_o;

  always #5 clk = ~clk;

  scratchpad_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .scratchpad_write_o(scratchpad_write_o), .scratchpad_addr_o(scratchpad_addr_o),
    .scratchpad_wdata_o(scratchpad_wdata_o), .scratchpad_mask_o(scratchpad_mask_o),
    .scratchpad_rdata_i(scratchpad_rdata_i)
  );

  // Memory behind the port: registered read, byte-masked write at the clock edge.
  logic [63:0] env_mem [0:63];
  always @(posedge clk) begin
    scratchpad_rdata_i <= env_mem[scratchpad_addr_o[5:0]];
    if (scratchpad_write_o)
      for (int b = 0; b < 8; b++)
        if (scratchpad_mask_o[b]) env_mem[scratchpad_addr_o[5:0]][8*b +: 8] = scratchpad_wdata_o[8*b +: 8];
  end

  bit          v [N];
  bit          w [N];
  logic [AW-1:0] ad [N];
  logic [63:0] wd [N];
  logic [7:0]  mk [N];

  int          m_starve, m_last, mp_id;
  bit          mp_v;
  logic [63:0] mp_d;
  logic [63:0] m_mem [0:63];

  logic [N-1:0] last_ready, last_rsp_v;
  logic [63:0]  last_rdata;
  int n_chk = 0;
  int n_fail = 0;
  int win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pred(input bit r);
    if (r) return -1;
    if (v[0] && m_starve < MAXW) return 0;
    for (int k = 1; k < N; k++) begin
      int idx;
      idx = ((m_last - 1 + k) % (N - 1)) + 1;
      if (v[idx]) return idx;
    end
    if (v[0]) return 0;
    return -1;
  endfunction

  task automatic step(input bit r, input bit clr, output int g);
    bit any_np;
    logic [63:0] eg;
    rst = r;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = v[i];
      req_write[i]           = w[i];
      req_addr[i*AW +: AW]   = ad[i];
      req_wdata[i*DW +: DW]  = wd[i];
      req_mask[i*MW +: MW]   = mk[i];
    end
    #3;
    g  = pred(r);
    eg = (g >= 0) ? (64'd1 << g) : 64'd0;
    last_ready = req_ready;
    last_rsp_v = rsp_valid;
    last_rdata = rsp_rdata;
    chk("ready", req_ready, eg);
    chk("rsp_valid", rsp_valid, (!r && mp_v) ? (64'd1 << mp_id) : 64'd0);
    chk("rsp_rdata", rsp_rdata, (!r && mp_v) ? mp_d : 64'd0);
    chk("mem_write", scratchpad_write_o, (g >= 0) ? 64'(w[g]) : 64'd0);
    chk("mem_addr", scratchpad_addr_o, (g >= 0) ? 64'(ad[g]) : 64'd0);
    chk("mem_mask", scratchpad_mask_o, (g >= 0) ? 64'(mk[g]) : 64'd0);
    chk("mem_wdata", scratchpad_wdata_o, (g >= 0) ? wd[g] : 64'd0);
    @(posedge clk);
    #1;
    if (r) begin
      mp_v = 0; m_starve = 0; m_last = N - 1;
    end else begin
      any_np = 0;
      for (int i = 1; i < N; i++) any_np |= v[i];
      mp_v = (g >= 0);
      if (g >= 0) begin
        mp_id = g;
        if (w[g]) begin
          mp_d = 64'd0;
          for (int b = 0; b < 8; b++)
            if (mk[g][b]) m_mem[ad[g][5:0]][8*b +: 8] = wd[g][8*b +: 8];
        end else begin
          mp_d = m_mem[ad[g][5:0]];
        end
      end
      if (g == 0 && any_np) m_starve = (m_starve < MAXW) ? m_starve + 1 : MAXW;
      else if (g > 0 || !any_np) m_starve = 0;
      if (g > 0) m_last = g;
      if (clr && g >= 0) v[g] = 0;
    end
  endtask

  task automatic set_req(input int i, input bit wr, input int a, input logic [63:0] d, input logic [7:0] m);
    v[i] = 1; w[i] = wr; ad[i] = AW'(a); wd[i] = d; mk[i] = m;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) v[i] = 0;
  endtask

  initial begin
    for (int a = 0; a < 64; a++) begin env_mem[a] = '0; m_mem[a] = '0; end
    for (int i = 0; i < N; i++) begin v[i] = 0; w[i] = 0; ad[i] = '0; wd[i] = '0; mk[i] = '0; end
    mp_v = 0; mp_id = 0; mp_d = '0; m_starve = 0; m_last = N - 1;
    rst = 1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_mask = '0;
    @(posedge clk); #1;

    // Reset state, with a request pending that must not be granted.
    set_req(1, 0, 3, 0, 8'hFF);
    step(1, 0, win); chk("rst_ready", last_ready, 0);
    step(1, 0, win); chk("rst_rsp", last_rsp_v, 0);
    idle_all();

    // Write by requester 0, then read back by requester 1.
    set_req(0, 1, 'h10, 64'hDEADBEEF_00C0FFEE, 8'hFF);
    step(0, 1, win); chk("wr_grant", last_ready, 3'b001);
    set_req(1, 0, 'h10, 64'd0, 8'hFF);
    step(0, 1, win); chk("rd_grant", last_ready, 3'b010); chk("wr_ack", last_rsp_v, 3'b001);
    chk("wr_ack_data", last_rdata, 0);
    step(0, 0, win); chk("rd_rsp", last_rsp_v, 3'b010);
    chk("rd_data", last_rdata, 64'hDEADBEEF_00C0FFEE);

    // Round-robin between requesters 1 and 2.
    step(1, 0, win);
    set_req(1, 0, 1, 0, 8'h00); set_req(2, 0, 2, 0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, win);
      chk("rr_grant", last_ready, (i % 2 == 0) ? 3'b010 : 3'b100);
      if (i > 0) chk("rr_rsp", last_rsp_v, (i % 2 == 0) ? 3'b100 : 3'b010);
    end
    idle_all();
    step(0, 0, win); chk("rr_rsp_last", last_rsp_v, 3'b100);

    // Starvation bound: 0 wins four times, then 1.
    step(1, 0, win);
    set_req(0, 0, 5, 0, 8'h01); set_req(1, 0, 6, 0, 8'h01);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, win);
      chk("starve_grant", last_ready, (i % 5 == 4) ? 3'b010 : 3'b001);
    end
    idle_all();

    // Requester 0 alone: always granted, counter never advances.
    step(1, 0, win);
    set_req(0, 0, 7, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, win); chk("prio_only", last_ready, 3'b001);
    end
    set_req(1, 0, 8, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, win); chk("prio_then_np", last_ready, (i == 4) ? 3'b010 : 3'b001);
    end
    idle_all();

    // Masked write over zero.
    step(1, 0, win);
    set_req(2, 1, 'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    step(0, 1, win); chk("mask_wr_grant", last_ready, 3'b100);
    set_req(1, 0, 'h20, 0, 8'hFF);
    step(0, 1, win);
    step(0, 0, win); chk("mask_rsp", last_rsp_v, 3'b010);
    chk("mask_data", last_rdata, 64'h0000_0000_FFFF_FFFF);

    // Reset in the response cycle drops the response.
    set_req(1, 0, 'h10, 0, 8'hFF);
    step(0, 1, win); chk("pre_rst_grant", last_ready, 3'b010);
    set_req(0, 0, 'h10, 0, 8'hFF); set_req(1, 0, 'h10, 0, 8'hFF);
    step(1, 0, win); chk("rst_drop_rsp", last_rsp_v, 0); chk("rst_drop_data", last_rdata, 0);
    step(0, 0, win); chk("post_rst_grant", last_ready, 3'b001);
    idle_all();
    step(0, 0, win);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 99) < 60)
          set_req(i, 1'($urandom), int'($urandom_range(0, 63)), {$urandom, $urandom}, 8'($urandom));
      step($urandom_range(0, 99) < 3, 1, win);
    end
    idle_all();
    step(0, 0, win);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
